// File: rtl/pad_attr_pkg.sv
// Shared types for the pad-attribute configuration controller: attribute width,
// pad implementation types and the controller state encoding.
package pad_attr_pkg;

    localparam int unsigned AttrDw = 32;

    // Value 2 is the generic pad used by most of the pad ring.
    typedef enum logic [2:0] {
        PadTypeBidirStd = 3'd0,
        PadTypeBidirOd  = 3'd1,
        PadTypeGeneric  = 3'd2,
        PadTypeAnalog   = 3'd3,
        PadTypeInvalid  = 3'd7
    } pad_type_e;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SETTLE,
        RESP
    } cfg_state_e;

    typedef logic [AttrDw-1:0] pad_attr_t;

endpackage

// File: rtl/pad_attr_cfg_ctrl_if.sv
// Requester-side write/response bus of the pad-attribute controller; fields are
// packed per requester.
interface pad_attr_cfg_ctrl_if #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 3,
    parameter int unsigned AttrDw = 32
);
    logic [NumReq-1:0]        req_valid_i;
    logic [NumReq-1:0]        req_ready_o;
    logic [NumReq*IdxW-1:0]   req_pad_idx_i;
    logic [NumReq*AttrDw-1:0] req_attr_i;
    logic [NumReq-1:0]        rsp_valid_o;
    logic [AttrDw-1:0]        rsp_attr_o;
    logic                     rsp_err_o;

    modport master (
        output req_valid_i, req_pad_idx_i, req_attr_i,
        input  req_ready_o, rsp_valid_o, rsp_attr_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_pad_idx_i, req_attr_i,
        output req_ready_o, rsp_valid_o, rsp_attr_o, rsp_err_o
    );
endinterface

// File: rtl/pad_attr_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping; the pointer moves past the winner when advance_i is pulsed.
module pad_attr_rr_arb #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned ReqW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              enable_i,
    input  logic              advance_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [ReqW-1:0]   gnt_idx_o,
    output logic              gnt_valid_o
);
    logic [ReqW-1:0] ptr_reg;
    logic [ReqW-1:0] ptr_next;
    logic [ReqW-1:0] cand_idx [NumReq];

    // cand_idx[k] is the requester checked k-th, starting from the pointer.
    for (genvar gi = 0; gi < NumReq; gi++) begin : gen_cand
        assign cand_idx[gi] = ReqW'((32'(ptr_reg) + 32'(gi)) % NumReq);
        assign gnt_o[gi]    = enable_i && gnt_valid_o && (gnt_idx_o == ReqW'(gi));
    end

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!gnt_valid_o && req_i[cand_idx[k]]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand_idx[k];
            end
        end
    end

    assign ptr_next = ReqW'((32'(gnt_idx_o) + 32'd1) % NumReq);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else if (advance_i) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/pad_attr_cfg_ctrl.sv
// Serialises masked pad-attribute writes from several requesters onto a bank
// of pad registers: accept, apply, settle, then respond with the applied value.
module pad_attr_cfg_ctrl #(
    parameter int unsigned              NumPads      = 8,
    parameter int unsigned              NumReq       = 2,
    parameter int unsigned              AttrDw       = pad_attr_pkg::AttrDw,
    parameter pad_attr_pkg::pad_type_e  PadType      = pad_attr_pkg::PadTypeGeneric,
    parameter int unsigned              SettleCycles = 4,
    parameter logic [AttrDw-1:0]        ResetAttr    = '0,
    parameter int unsigned              IdxW         = (NumPads > 1) ? $clog2(NumPads) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    pad_attr_cfg_ctrl_if.slave        bus,
    input  logic [AttrDw-1:0]         warl_mask_i,
    output logic [NumPads*AttrDw-1:0] attr_o,
    output logic [NumPads-1:0]        attr_update_o,
    output logic                      busy_o
);
    import pad_attr_pkg::*;

    localparam int unsigned ReqW = (NumReq > 1) ? $clog2(NumReq) : 1;
    // An unsupported configuration simply never accepts a write.
    localparam bit CfgOk = (NumReq >= 1) && (NumReq <= 4) &&
                           (SettleCycles >= 1) && (SettleCycles <= 255) &&
                           (PadType != PadTypeInvalid);

    cfg_state_e        state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [ReqW-1:0]   owner_reg;
    logic [IdxW-1:0]   idx_reg;
    logic [AttrDw-1:0] req_attr_reg;
    logic [AttrDw-1:0] masked_reg;
    logic              err_reg;
    logic [AttrDw-1:0] rsp_attr_reg;
    logic              rsp_err_reg;

    logic [IdxW-1:0]   req_idx_arr  [NumReq];
    logic [AttrDw-1:0] req_attr_arr [NumReq];
    logic [ReqW-1:0]   gnt_idx;
    logic              gnt_valid;
    logic              arb_enable;
    logic              accept;
    logic              in_range;
    logic              resp_enter;

    for (genvar gi = 0; gi < NumReq; gi++) begin : gen_req
        assign req_idx_arr[gi]     = bus.req_pad_idx_i[gi*IdxW +: IdxW];
        assign req_attr_arr[gi]    = bus.req_attr_i[gi*AttrDw +: AttrDw];
        assign bus.rsp_valid_o[gi] = (state_reg == RESP) && (owner_reg == ReqW'(gi));
    end

    assign arb_enable = (state_reg == IDLE) && !rst_i && CfgOk;
    assign accept     = arb_enable && gnt_valid;
    assign in_range   = 32'(idx_reg) < NumPads;
    assign resp_enter = (state_reg == SETTLE) && (cnt_reg == 8'd0);

    pad_attr_rr_arb #(
        .NumReq (NumReq),
        .ReqW   (ReqW)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (bus.req_valid_i),
        .enable_i    (arb_enable),
        .advance_i   (accept),
        .gnt_o       (bus.req_ready_o),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = APPLY;
            end
            APPLY: begin
                state_next = SETTLE;
                cnt_next   = 8'(SettleCycles - 1);
            end
            SETTLE: begin
                if (cnt_reg == 8'd0) state_next = RESP;
                else                 cnt_next   = cnt_reg - 8'd1;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The mask is sampled only during APPLY; later mask changes never re-mask.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_reg    <= '0;
            idx_reg      <= '0;
            req_attr_reg <= '0;
            masked_reg   <= '0;
            err_reg      <= 1'b0;
            rsp_attr_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                owner_reg    <= gnt_idx;
                idx_reg      <= req_idx_arr[gnt_idx];
                req_attr_reg <= req_attr_arr[gnt_idx];
            end
            if (state_reg == APPLY) begin
                masked_reg <= in_range ? (req_attr_reg & warl_mask_i) : '0;
                err_reg    <= !in_range;
            end
            if (resp_enter) begin
                rsp_attr_reg <= masked_reg;
                rsp_err_reg  <= err_reg;
            end
        end
    end

    for (genvar gi = 0; gi < NumPads; gi++) begin : gen_pad
        logic [AttrDw-1:0] attr_reg;
        logic              upd_reg;
        logic              hit;

        assign hit = (state_reg == APPLY) && in_range && (idx_reg == IdxW'(gi));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                attr_reg <= ResetAttr;
                upd_reg  <= 1'b0;
            end else begin
                upd_reg <= hit;
                if (hit) attr_reg <= req_attr_reg & warl_mask_i;
            end
        end

        assign attr_o[gi*AttrDw +: AttrDw] = attr_reg;
        assign attr_update_o[gi]           = upd_reg;
    end

    assign bus.rsp_attr_o = rsp_attr_reg;
    assign bus.rsp_err_o  = rsp_err_reg;
    assign busy_o         = (state_reg != IDLE);

endmodule

// File: tb/tb_pad_attr_cfg_ctrl.sv
// Directed bench for pad_attr_cfg_ctrl: one instance with SettleCycles=4 and a
// widened index, one with SettleCycles=1.
module tb_pad_attr_cfg_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0]  mask_a, mask_b;
    logic [255:0] attr_a, attr_b;
    logic [7:0]   upd_a, upd_b;
    logic         busy_a, busy_b;
    logic [255:0] exp_attr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pad_attr_cfg_ctrl_if #(.NumReq(2), .IdxW(4), .AttrDw(32)) bus_a ();
    pad_attr_cfg_ctrl_if #(.NumReq(2), .IdxW(3), .AttrDw(32)) bus_b ();

    // Index widened to 4 bits so out-of-range pad 9 can be requested.
    pad_attr_cfg_ctrl #(
        .NumPads(8), .NumReq(2), .AttrDw(32), .PadType(pad_attr_pkg::PadTypeGeneric),
        .SettleCycles(4), .ResetAttr(32'h0), .IdxW(4)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a), .warl_mask_i(mask_a),
        .attr_o(attr_a), .attr_update_o(upd_a), .busy_o(busy_a)
    );

    pad_attr_cfg_ctrl #(
        .NumPads(8), .NumReq(2), .AttrDw(32), .PadType(pad_attr_pkg::PadTypeGeneric),
        .SettleCycles(1), .ResetAttr(32'h0), .IdxW(3)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b), .warl_mask_i(mask_b),
        .attr_o(attr_b), .attr_update_o(upd_b), .busy_o(busy_b)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_attr = '0;
    endtask

    // Single write on dut_a; ends at its RESP cycle (cycle 6).
    task automatic wr_a(input int r, input int idx, input logic [31:0] attr, input logic [31:0] mask);
        logic        in_rng;
        logic [31:0] exp_v;
        logic [7:0]  exp_upd;
        in_rng  = (idx < 8);
        exp_v   = in_rng ? (attr & mask) : 32'h0;
        exp_upd = in_rng ? 8'(1 << idx) : 8'h0;

        @(negedge clk);
        bus_a.req_valid_i   = 2'(1 << r);
        bus_a.req_pad_idx_i = {2{4'(idx)}};
        bus_a.req_attr_i    = {2{attr}};
        mask_a              = mask;
        #1;
        chk("ready_c0", 256'(bus_a.req_ready_o), 256'(1 << r));
        chk("busy_c0", 256'(busy_a), 256'(0));

        @(negedge clk);
        bus_a.req_valid_i = '0;
        #1;
        chk("busy_apply", 256'(busy_a), 256'(1));
        chk("upd_apply", 256'(upd_a), 256'(0));
        if (in_rng) exp_attr[idx*32 +: 32] = exp_v;

        @(negedge clk);
        #1;
        chk("attr_c2", attr_a, exp_attr);
        chk("upd_c2", 256'(upd_a), 256'(exp_upd));
        mask_a = 32'h0;

        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            #1;
            chk("rsp_settle", 256'(bus_a.rsp_valid_o), 256'(0));
            chk("upd_settle", 256'(upd_a), 256'(0));
        end
        chk("attr_no_remask", attr_a, exp_attr);

        @(negedge clk);
        #1;
        chk("rsp_valid", 256'(bus_a.rsp_valid_o), 256'(1 << r));
        chk("rsp_attr", 256'(bus_a.rsp_attr_o), 256'(exp_v));
        chk("rsp_err", 256'(bus_a.rsp_err_o), 256'(!in_rng));
        $display("txn a: req%0d idx=%0d attr=0x%08h applied=0x%08h err=%0b",
                 r, idx, attr, bus_a.rsp_attr_o, bus_a.rsp_err_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic rsp_seen;
        int   g;

        bus_a.req_valid_i = '0; bus_a.req_pad_idx_i = '0; bus_a.req_attr_i = '0;
        bus_b.req_valid_i = '0; bus_b.req_pad_idx_i = '0; bus_b.req_attr_i = '0;
        mask_a = '1; mask_b = '1;
        exp_attr = '0;

        // Reset state, with requests pending during reset.
        repeat (2) @(negedge clk);
        bus_a.req_valid_i = 2'b11;
        bus_b.req_valid_i = 2'b11;
        #1;
        chk("rst_ready_a", 256'(bus_a.req_ready_o), 256'(0));
        chk("rst_ready_b", 256'(bus_b.req_ready_o), 256'(0));
        chk("rst_busy", 256'(busy_a), 256'(0));
        chk("rst_attr", attr_a, 256'(0));
        chk("rst_upd", 256'(upd_a), 256'(0));
        chk("rst_rsp_valid", 256'(bus_a.rsp_valid_o), 256'(0));
        chk("rst_rsp_attr", 256'(bus_a.rsp_attr_o), 256'(0));
        chk("rst_rsp_err", 256'(bus_a.rsp_err_o), 256'(0));
        bus_a.req_valid_i = '0;
        bus_b.req_valid_i = '0;
        rst = 1'b0;

        // Single masked write with full latency check.
        wr_a(0, 3, 32'hFFFF_FFFF, 32'h0000_00F3);
        @(negedge clk);
        #1;
        chk("t1_idle_busy", 256'(busy_a), 256'(0));
        chk("t1_rsp_drop", 256'(bus_a.rsp_valid_o), 256'(0));
        chk("t1_rsp_hold", 256'(bus_a.rsp_attr_o), 256'(32'hF3));

        // Two requesters continuously valid from reset: alternate grants, 7 cycles apart.
        do_reset();
        mask_a              = '1;
        bus_a.req_pad_idx_i = {4'd2, 4'd1};
        bus_a.req_attr_i    = {32'h0000_000B, 32'h0000_000A};
        bus_a.req_valid_i   = 2'b11;
        for (int c = 0; c < 28; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            g = (c / 7) % 2;
            chk("t2_ready", 256'(bus_a.req_ready_o), (c % 7 == 0) ? 256'(1 << g) : 256'(0));
            chk("t2_busy", 256'(busy_a), (c % 7 == 0) ? 256'(0) : 256'(1));
            chk("t2_rsp", 256'(bus_a.rsp_valid_o), (c % 7 == 6) ? 256'(1 << g) : 256'(0));
            if (c % 7 == 0) $display("txn a: cycle %0d accept ready=%b", c, bus_a.req_ready_o);
        end
        @(negedge clk);
        bus_a.req_valid_i = '0;
        #1;
        exp_attr[1*32 +: 32] = 32'hA;
        exp_attr[2*32 +: 32] = 32'hB;
        chk("t2_attr", attr_a, exp_attr);

        // Out-of-range pad index.
        wr_a(1, 9, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

        // Reset during the second SETTLE cycle aborts silently.
        @(negedge clk);
        bus_a.req_valid_i   = 2'b01;
        bus_a.req_pad_idx_i = {2{4'd2}};
        bus_a.req_attr_i    = {2{32'h5}};
        mask_a              = '1;
        #1;
        chk("t4_ready", 256'(bus_a.req_ready_o), 256'(1));
        @(negedge clk);
        bus_a.req_valid_i = '0;
        @(negedge clk);
        #1;
        exp_attr[2*32 +: 32] = 32'h5;
        chk("t4_attr_written", attr_a, exp_attr);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_attr = '0;
        chk("t4_busy", 256'(busy_a), 256'(0));
        chk("t4_attr_reverted", attr_a, exp_attr);
        rsp_seen = 1'b0;
        if (bus_a.rsp_valid_o != 2'b00) rsp_seen = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (bus_a.rsp_valid_o != 2'b00) rsp_seen = 1'b1;
        end
        chk("t4_no_rsp", 256'(rsp_seen), 256'(0));
        $display("txn a: req0 idx=2 aborted by reset");

        // Same value written twice back to back: both pulse.
        wr_a(0, 0, 32'h1, 32'hFFFF_FFFF);
        wr_a(0, 0, 32'h1, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("t5_attr0", 256'(attr_a[31:0]), 256'(32'h1));

        // SettleCycles=1: RESP in cycle 3, next accept in cycle 4.
        @(negedge clk);
        bus_b.req_valid_i   = 2'b01;
        bus_b.req_pad_idx_i = {2{3'd4}};
        bus_b.req_attr_i    = {2{32'h3C}};
        mask_b              = 32'hF3;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge clk);
            if (c == 5) bus_b.req_valid_i = '0;
            #1;
            chk("t6_ready", 256'(bus_b.req_ready_o), (c == 0 || c == 4) ? 256'(1) : 256'(0));
            chk("t6_rsp", 256'(bus_b.rsp_valid_o), (c == 3 || c == 7) ? 256'(1) : 256'(0));
            if (c == 2 || c == 6) chk("t6_upd", 256'(upd_b), 256'(8'h10));
            if (c == 3 || c == 7) begin
                chk("t6_rsp_attr", 256'(bus_b.rsp_attr_o), 256'(32'h30));
                $display("txn b: cycle %0d rsp applied=0x%08h", c, bus_b.rsp_attr_o);
            end
        end
        chk("t6_attr", 256'(attr_b[4*32 +: 32]), 256'(32'h30));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pad_attr_cfg_ctrl.md
Name: pad_attr_cfg_ctrl

Overview:
- Serialises pad-attribute writes from NumReq requesters onto a bank of NumPads pad-attribute registers.
- Round-robin arbitration; one accepted write at a time.
- Each write is masked by the pad primitive's supported-attribute (WARL) mask, applied, held for a settle window, then acknowledged with the value actually applied.
- Sits between the pinmux/padctrl register interfaces and the prim_pad_attr hierarchy, parameterised by the same PadType.

Parameters:
- NumPads, 8, number of pad-attribute registers; index width is clog2(NumPads) with a minimum of 1.
- NumReq, 2, number of requesters; supported range 1..4.
- AttrDw, 32, attribute word width.
- PadType, 2, pad implementation type; carried through to the prim_pad_attr instance that drives warl_mask_i.
- SettleCycles, 4, cycles held in SETTLE after an apply; legal range 1..255.
- ResetAttr, 0, value of every attr_o word after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NumReq  per-requester write request.
- req_ready_o  out  NumReq  per-requester accept; one-hot or zero.
- req_pad_idx_i  in  NumReq*IdxW  target pad index, packed per requester.
- req_attr_i  in  NumReq*AttrDw  requested attribute, packed per requester.
- warl_mask_i  in  AttrDw  supported-attribute mask from prim_pad_attr.
- rsp_valid_o  out  NumReq  one-cycle completion pulse to the owning requester.
- rsp_attr_o  out  AttrDw  applied (masked) value, valid with rsp_valid_o.
- rsp_err_o  out  1  out-of-range pad index, valid with rsp_valid_o.
- attr_o  out  NumPads*AttrDw  current attribute per pad.
- attr_update_o  out  NumPads  one-cycle pulse when the matching attr_o word changes.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, active-high; clk_i only):
  - state=IDLE, rr_ptr=0, all attr_o words=ResetAttr.
  - attr_update_o=0, rsp_valid_o=0, rsp_attr_o=0, rsp_err_o=0, busy_o=0, req_ready_o=0.
  - Reset mid-operation aborts the in-flight write silently: no rsp_valid_o; an attr_o word already written still reverts to ResetAttr.
- FSM states: IDLE -> APPLY -> SETTLE -> RESP -> IDLE.
- IDLE:
  - Grant is combinational: the first valid requester at or after rr_ptr, wrapping.
  - req_ready_o[g]=1 only in IDLE and only for the granted requester.
  - On handshake, latch g, pad index and attribute; go to APPLY; set rr_ptr=(g+1) mod NumReq.
  - Ungranted requesters must hold valid and payload until accepted.
- APPLY (1 cycle):
  - masked = req_attr & warl_mask_i, sampled in this cycle.
  - If idx < NumPads: the clock edge ending APPLY writes attr_o[idx]=masked and registers attr_update_o[idx]=1 for exactly the next cycle.
  - The pulse fires even when the value is unchanged.
  - If idx >= NumPads: no write, no pulse, err flag latched.
  - Go to SETTLE and load the counter with SettleCycles-1.
- SETTLE:
  - Decrement each cycle; leave for RESP when the counter is 0.
  - Duration is exactly SettleCycles cycles.
- RESP (1 cycle):
  - rsp_valid_o[g]=1; rsp_attr_o=masked, or 0 on error; rsp_err_o=err.
  - Go to IDLE. No new accept is possible in the RESP cycle.
- Latency, with the handshake in cycle 0:
  - APPLY in cycle 1.
  - attr_o new value and update pulse in cycle 2.
  - RESP in cycle SettleCycles+2.
  - Next accept no earlier than cycle SettleCycles+3.
- rsp_attr_o and rsp_err_o hold their last values outside RESP.
- warl_mask_i changes take effect only at the next APPLY; already-applied words are not re-masked.

Decomposition:
- Shared package pad_attr_pkg: AttrDw constant; pad_type_e enum (the value 2 is the generic pad type); cfg_state_e {IDLE, APPLY, SETTLE, RESP}; pad_attr_t = logic [AttrDw-1:0].
- One sub-module: pad_attr_rr_arb, a NumReq-wide round-robin arbiter with a pointer-advance input.

Test Plan:
1. Reset, then req0 writes idx=3, attr=0xFFFF_FFFF, mask=0x0000_00F3, SettleCycles=4:
   - ready0 in cycle 0.
   - attr_o[3]=0xF3 and attr_update_o[3] pulse in cycle 2.
   - rsp_valid_o[0] in cycle 6 with rsp_attr_o=0xF3, rsp_err_o=0.
2. req0 and req1 valid together, continuously, from reset:
   - Grants in order 0,1,0,1.
   - Each accept is 7 cycles after the previous one.
   - busy_o is low only in the accept cycles.
3. req1 writes idx=9 with NumPads=8:
   - No attr_update_o pulse; all attr_o unchanged.
   - rsp_valid_o[1] with rsp_err_o=1, rsp_attr_o=0.
4. rst_i asserted in the second SETTLE cycle after a write to idx=2, attr=0x5:
   - Next cycle: state IDLE, attr_o[2]=ResetAttr.
   - No rsp_valid_o ever issued for that request.
5. Back-to-back write of the same value 0x1 to idx=0:
   - attr_update_o[0] pulses on both writes.
   - attr_o[0] stays 0x1.
6. SettleCycles=1, single write:
   - rsp_valid_o in cycle 3.
   - Next handshake accepted in cycle 4.
